// File: rtl/axil_pkg.sv
// axil_pkg: AXI-Lite response codes and fault-mode encoding shared by the fault slave.
package axil_pkg;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    MODE_OKAY   = 2'b00,
    MODE_SLVERR = 2'b01,
    MODE_DECERR = 2'b10,
    MODE_HANG   = 2'b11
  } fault_mode_t;

  function automatic logic [1:0] mode_resp(input fault_mode_t m);
    return m == MODE_SLVERR ? RESP_SLVERR : m == MODE_DECERR ? RESP_DECERR : RESP_OKAY;
  endfunction
endpackage

// File: rtl/axil_fault_dly.sv
// axil_fault_dly: loadable down-counter; o_done flags the last cycle of the loaded delay.
module axil_fault_dly #(
  parameter int G_W = 8
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_load,
  input  logic [G_W-1:0] i_val,
  output logic           o_done
);
  logic [G_W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) r_cnt <= '0;
    else if (i_load) r_cnt <= i_val;
    else if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
  end

  // Loaded value D keeps the owner in its delay state for exactly D cycles.
  assign o_done = r_cnt <= G_W'(1);
endmodule

// File: rtl/axil_fault_slave.sv
// axil_fault_slave: AXI-Lite register-file responder with programmable response code,
// response delay, or hang, independently for the write and read paths.
module axil_fault_slave
  import axil_pkg::*;
#(
  parameter int G_ADDR_W = 20,
  parameter int G_DATA_W = 32,
  parameter int G_REG_N  = 8,
  parameter int G_DLY_W  = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [1:0]            i_wr_mode,
  input  logic [1:0]            i_rd_mode,
  input  logic [G_DLY_W-1:0]    i_delay,
  input  logic                  i_release,
  output logic                  s_axil_awready,
  input  logic                  s_axil_awvalid,
  input  logic [G_ADDR_W-1:0]   s_axil_awaddr,
  input  logic [2:0]            s_axil_awprot,
  output logic                  s_axil_wready,
  input  logic                  s_axil_wvalid,
  input  logic [G_DATA_W-1:0]   s_axil_wdata,
  input  logic [G_DATA_W/8-1:0] s_axil_wstrb,
  input  logic                  s_axil_bready,
  output logic                  s_axil_bvalid,
  output logic [1:0]            s_axil_bresp,
  output logic                  s_axil_arready,
  input  logic                  s_axil_arvalid,
  input  logic [G_ADDR_W-1:0]   s_axil_araddr,
  input  logic [2:0]            s_axil_arprot,
  input  logic                  s_axil_rready,
  output logic                  s_axil_rvalid,
  output logic [G_DATA_W-1:0]   s_axil_rdata,
  output logic [1:0]            s_axil_rresp,
  output logic [15:0]           o_wr_cnt,
  output logic [15:0]           o_rd_cnt
);
  localparam int IDX_W  = $clog2(G_REG_N);
  localparam int STRB_W = G_DATA_W / 8;

  typedef logic [1:0] state_t;
  localparam state_t W_IDLE = 2'd0, W_DLY = 2'd1, W_RESP = 2'd2, W_HANG = 2'd3;
  localparam state_t R_IDLE = 2'd0, R_DLY = 2'd1, R_RESP = 2'd2, R_HANG = 2'd3;

  logic                r_live;
  state_t              r_wr_st, r_rd_st;
  logic                r_aw_held, r_w_held;
  logic [G_ADDR_W-1:0] r_awaddr;
  logic [G_DATA_W-1:0] r_wdata;
  logic [STRB_W-1:0]   r_wstrb;
  logic [1:0]          r_bresp, r_rresp;
  logic                r_whang, r_rhang;
  logic [G_DATA_W-1:0] r_rdata;
  logic [G_DATA_W-1:0] r_regs [G_REG_N];
  logic [15:0]         r_wr_cnt, r_rd_cnt;

  logic                w_aw_hs, w_w_hs, w_ar_hs, w_b_hs, w_r_hs;
  logic [G_ADDR_W-1:0] w_awaddr;
  logic [G_DATA_W-1:0] w_wdata;
  logic [STRB_W-1:0]   w_wstrb;
  logic                w_wdec, w_woor, w_whang, w_wok;
  logic                w_roor, w_rhang, w_rok;
  fault_mode_t         w_wmode, w_rmode;
  logic [IDX_W-1:0]    w_widx, w_ridx;
  logic                w_wdly_done, w_rdly_done;
  state_t              w_wr_nx, w_rd_nx;
  logic                w_unused;

  assign s_axil_awready = r_live && r_wr_st == W_IDLE && !r_aw_held;
  assign s_axil_wready  = r_live && r_wr_st == W_IDLE && !r_w_held;
  assign s_axil_arready = r_live && r_rd_st == R_IDLE;
  assign s_axil_bvalid  = r_wr_st == W_RESP;
  assign s_axil_rvalid  = r_rd_st == R_RESP;
  assign s_axil_bresp   = r_bresp;
  assign s_axil_rresp   = r_rresp;
  assign s_axil_rdata   = r_rdata;
  assign o_wr_cnt       = r_wr_cnt;
  assign o_rd_cnt       = r_rd_cnt;

  assign w_aw_hs = s_axil_awvalid && s_axil_awready;
  assign w_w_hs  = s_axil_wvalid && s_axil_wready;
  assign w_ar_hs = s_axil_arvalid && s_axil_arready;
  assign w_b_hs  = s_axil_bvalid && s_axil_bready;
  assign w_r_hs  = s_axil_rvalid && s_axil_rready;

  // Decide in the cycle of the final handshake, using live bus values for whichever half just arrived.
  assign w_awaddr = r_aw_held ? r_awaddr : s_axil_awaddr;
  assign w_wdata  = r_w_held ? r_wdata : s_axil_wdata;
  assign w_wstrb  = r_w_held ? r_wstrb : s_axil_wstrb;
  assign w_wdec   = r_wr_st == W_IDLE && (r_aw_held || w_aw_hs) && (r_w_held || w_w_hs);
  assign w_wmode  = fault_mode_t'(i_wr_mode);
  assign w_woor   = |w_awaddr[G_ADDR_W-1:IDX_W+2];
  assign w_whang  = !w_woor && w_wmode == MODE_HANG;
  assign w_wok    = !w_woor && w_wmode == MODE_OKAY;
  assign w_widx   = w_awaddr[IDX_W+1:2];

  assign w_rmode = fault_mode_t'(i_rd_mode);
  assign w_roor  = |s_axil_araddr[G_ADDR_W-1:IDX_W+2];
  assign w_rhang = !w_roor && w_rmode == MODE_HANG;
  assign w_rok   = !w_roor && w_rmode == MODE_OKAY;
  assign w_ridx  = s_axil_araddr[IDX_W+1:2];

  assign w_unused = ^{s_axil_awprot, s_axil_arprot, w_awaddr[1:0], s_axil_araddr[1:0]};

  assign w_wr_nx = r_wr_st == W_IDLE ? (w_wdec ? (|i_delay ? W_DLY : w_whang ? W_HANG : W_RESP) : W_IDLE)
                 : r_wr_st == W_DLY  ? (w_wdly_done ? (r_whang ? W_HANG : W_RESP) : W_DLY)
                 : r_wr_st == W_RESP ? (s_axil_bready ? W_IDLE : W_RESP)
                 : (i_release ? W_IDLE : W_HANG);

  assign w_rd_nx = r_rd_st == R_IDLE ? (w_ar_hs ? (|i_delay ? R_DLY : w_rhang ? R_HANG : R_RESP) : R_IDLE)
                 : r_rd_st == R_DLY  ? (w_rdly_done ? (r_rhang ? R_HANG : R_RESP) : R_DLY)
                 : r_rd_st == R_RESP ? (s_axil_rready ? R_IDLE : R_RESP)
                 : (i_release ? R_IDLE : R_HANG);

  axil_fault_dly #(.G_W(G_DLY_W)) u_wdly (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_load(w_wdec),
    .i_val (i_delay),
    .o_done(w_wdly_done)
  );

  axil_fault_dly #(.G_W(G_DLY_W)) u_rdly (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_load(w_ar_hs),
    .i_val (i_delay),
    .o_done(w_rdly_done)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_live    <= 1'b0;
      r_wr_st   <= W_IDLE;
      r_aw_held <= 1'b0;
      r_w_held  <= 1'b0;
      r_awaddr  <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_bresp   <= RESP_OKAY;
      r_whang   <= 1'b0;
      r_wr_cnt  <= '0;
    end else begin
      r_live  <= 1'b1;
      r_wr_st <= w_wr_nx;
      if (w_aw_hs) begin
        r_aw_held <= 1'b1;
        r_awaddr  <= s_axil_awaddr;
      end
      if (w_w_hs) begin
        r_w_held <= 1'b1;
        r_wdata  <= s_axil_wdata;
        r_wstrb  <= s_axil_wstrb;
      end
      if (w_wdec) begin
        r_aw_held <= 1'b0;
        r_w_held  <= 1'b0;
        r_bresp   <= w_woor ? RESP_DECERR : mode_resp(w_wmode);
        r_whang   <= w_whang;
      end
      if (w_b_hs) r_wr_cnt <= r_wr_cnt + 16'd1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rd_st  <= R_IDLE;
      r_rresp  <= RESP_OKAY;
      r_rdata  <= '0;
      r_rhang  <= 1'b0;
      r_rd_cnt <= '0;
    end else begin
      r_rd_st <= w_rd_nx;
      if (w_ar_hs) begin
        r_rresp <= w_roor ? RESP_DECERR : mode_resp(w_rmode);
        r_rdata <= w_rok ? r_regs[w_ridx] : '0;
        r_rhang <= w_rhang;
      end
      if (w_r_hs) r_rd_cnt <= r_rd_cnt + 16'd1;
    end
  end

  // A read captured in the same cycle as a write decision sees the pre-write value.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int k = 0; k < G_REG_N; k++) r_regs[k] <= '0;
    end else if (w_wdec && w_wok) begin
      for (int b = 0; b < STRB_W; b++)
        if (w_wstrb[b]) r_regs[w_widx][8*b +: 8] <= w_wdata[8*b +: 8];
    end
  end
endmodule

// File: tb/tb_axil_fault_slave.sv
// tb_axil_fault_slave: directed table of AXI-Lite transactions plus hand-written
// sequences for delay, backpressure, hang/release, reset abort and same-register races.
module tb_axil_fault_slave;
  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  wr_mode, rd_mode;
  logic [7:0]  delay;
  logic        release_p;
  logic        awready, awvalid, wready, wvalid, bready, bvalid, arready, arvalid, rready, rvalid;
  logic [19:0] awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic [15:0] wr_cnt, rd_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_w   = 0;
  int exp_r   = 0;

  always #5 clk = ~clk;

  axil_fault_slave dut (
    .i_clk(clk), .i_rst(rst), .i_wr_mode(wr_mode), .i_rd_mode(rd_mode), .i_delay(delay),
    .i_release(release_p),
    .s_axil_awready(awready), .s_axil_awvalid(awvalid), .s_axil_awaddr(awaddr), .s_axil_awprot(awprot),
    .s_axil_wready(wready), .s_axil_wvalid(wvalid), .s_axil_wdata(wdata), .s_axil_wstrb(wstrb),
    .s_axil_bready(bready), .s_axil_bvalid(bvalid), .s_axil_bresp(bresp),
    .s_axil_arready(arready), .s_axil_arvalid(arvalid), .s_axil_araddr(araddr), .s_axil_arprot(arprot),
    .s_axil_rready(rready), .s_axil_rvalid(rvalid), .s_axil_rdata(rdata), .s_axil_rresp(rresp),
    .o_wr_cnt(wr_cnt), .o_rd_cnt(rd_cnt)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic wr(input logic [19:0] a, input logic [31:0] d, input logic [3:0] s,
                    output logic [1:0] resp, output int lat);
    int t = 0;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
    while (!(awready && wready) && t < 50) begin @(negedge clk); t++; end
    chk("wr_accept", {31'b0, awready && wready}, 32'd1);
    @(posedge clk); @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    lat = 1;
    while (!bvalid && lat < 50) begin @(negedge clk); lat++; end
    resp = bresp;
    if (bvalid) exp_w++;
    bready = 1'b1; @(posedge clk); @(negedge clk); bready = 1'b0;
  endtask

  task automatic rd(input logic [19:0] a, output logic [1:0] resp, output logic [31:0] d, output int lat);
    int t = 0;
    araddr = a; arvalid = 1'b1;
    while (!arready && t < 50) begin @(negedge clk); t++; end
    chk("rd_accept", {31'b0, arready}, 32'd1);
    @(posedge clk); @(negedge clk);
    arvalid = 1'b0;
    lat = 1;
    while (!rvalid && lat < 50) begin @(negedge clk); lat++; end
    resp = rresp; d = rdata;
    if (rvalid) exp_r++;
    rready = 1'b1; @(posedge clk); @(negedge clk); rready = 1'b0;
  endtask

  typedef struct {
    logic        is_wr;
    logic [1:0]  mode;
    logic [19:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  resp;
    logic [31:0] rdata;
  } vec_t;

  vec_t tbl[18];

  initial begin
    logic [1:0]  r;
    logic [31:0] d;
    int          lat;
    int          seen;
    tbl[0]  = '{1'b1, 2'd0, 20'h04, 32'hDEADBEEF, 4'hF, 2'b00, 32'h0};
    tbl[1]  = '{1'b0, 2'd0, 20'h04, 32'h0,        4'h0, 2'b00, 32'hDEADBEEF};
    tbl[2]  = '{1'b1, 2'd0, 20'h0C, 32'hAABBCCDD, 4'hF, 2'b00, 32'h0};
    tbl[3]  = '{1'b1, 2'd0, 20'h0C, 32'h11223344, 4'h5, 2'b00, 32'h0};
    tbl[4]  = '{1'b0, 2'd0, 20'h0C, 32'h0,        4'h0, 2'b00, 32'hAA22CC44};
    tbl[5]  = '{1'b1, 2'd1, 20'h08, 32'h5,        4'hF, 2'b10, 32'h0};
    tbl[6]  = '{1'b0, 2'd0, 20'h08, 32'h0,        4'h0, 2'b00, 32'h0};
    tbl[7]  = '{1'b0, 2'd0, 20'h40, 32'h0,        4'h0, 2'b11, 32'h0};
    tbl[8]  = '{1'b1, 2'd0, 20'h40, 32'h1,        4'hF, 2'b11, 32'h0};
    tbl[9]  = '{1'b0, 2'd1, 20'h04, 32'h0,        4'h0, 2'b10, 32'h0};
    tbl[10] = '{1'b0, 2'd2, 20'h04, 32'h0,        4'h0, 2'b11, 32'h0};
    tbl[11] = '{1'b1, 2'd2, 20'h04, 32'h0,        4'hF, 2'b11, 32'h0};
    tbl[12] = '{1'b0, 2'd0, 20'h04, 32'h0,        4'h0, 2'b00, 32'hDEADBEEF};
    tbl[13] = '{1'b1, 2'd0, 20'h1C, 32'h12345678, 4'h8, 2'b00, 32'h0};
    tbl[14] = '{1'b0, 2'd0, 20'h1C, 32'h0,        4'h0, 2'b00, 32'h12000000};
    tbl[15] = '{1'b1, 2'd0, 20'h07, 32'hCAFEF00D, 4'hF, 2'b00, 32'h0};
    tbl[16] = '{1'b0, 2'd0, 20'h04, 32'h0,        4'h0, 2'b00, 32'hCAFEF00D};
    tbl[17] = '{1'b0, 2'd0, 20'h20, 32'h0,        4'h0, 2'b11, 32'h0};

    rst = 1'b1; wr_mode = 2'd0; rd_mode = 2'd0; delay = 8'd0; release_p = 1'b0;
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;
    awaddr = '0; araddr = '0; awprot = 3'd5; arprot = 3'd2; wdata = '0; wstrb = '0;
    repeat (3) @(negedge clk);
    chk("rst_readys", {29'b0, awready, wready, arready}, 32'd0);
    chk("rst_valids", {30'b0, bvalid, rvalid}, 32'd0);
    chk("rst_resps", {28'b0, bresp, rresp}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_cnts", {wr_cnt, rd_cnt}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("readys_after_rst", {29'b0, awready, wready, arready}, 32'd7);

    for (int i = 0; i < 18; i++) begin
      if (tbl[i].is_wr) begin
        wr_mode = tbl[i].mode;
        wr(tbl[i].addr, tbl[i].data, tbl[i].strb, r, lat);
        chk($sformatf("v%0d_bresp", i), {30'b0, r}, {30'b0, tbl[i].resp});
      end else begin
        rd_mode = tbl[i].mode;
        rd(tbl[i].addr, r, d, lat);
        chk($sformatf("v%0d_rresp", i), {30'b0, r}, {30'b0, tbl[i].resp});
        chk($sformatf("v%0d_rdata", i), d, tbl[i].rdata);
      end
      chk($sformatf("v%0d_lat", i), lat, 32'd1);
      chk($sformatf("v%0d_cnts", i), {wr_cnt, rd_cnt}, {exp_w[15:0], exp_r[15:0]});
      wr_mode = 2'd0; rd_mode = 2'd0;
    end

    // Delays: latency D+1, and i_delay/i_rd_mode sampled only at the decision cycle.
    delay = 8'd5;
    rd(20'h04, r, d, lat);
    chk("dly5_rd_lat", lat, 32'd6);
    chk("dly5_rd_data", d, 32'hCAFEF00D);
    delay = 8'd3;
    wr(20'h08, 32'h77, 4'hF, r, lat);
    chk("dly3_wr_lat", lat, 32'd4);
    delay = 8'd2;
    araddr = 20'h04; arvalid = 1'b1;
    @(posedge clk); @(negedge clk);
    arvalid = 1'b0; delay = 8'd0; rd_mode = 2'd1;
    lat = 1;
    while (!rvalid && lat < 50) begin @(negedge clk); lat++; end
    chk("dly_sampled_lat", lat, 32'd3);
    chk("dly_sampled_resp", {30'b0, rresp}, 32'd0);
    chk("dly_sampled_data", rdata, 32'hCAFEF00D);
    rready = 1'b1; @(posedge clk); @(negedge clk); rready = 1'b0; exp_r++;
    rd_mode = 2'd0;

    // Write backpressure with a stray release pulse that must be ignored.
    wr_mode = 2'd1;
    awaddr = 20'h0C; wdata = 32'h0; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    @(posedge clk); @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0; wr_mode = 2'd0;
    chk("bp_bvalid_first", {31'b0, bvalid}, 32'd1);
    for (int k = 0; k < 3; k++) begin
      release_p = (k == 1);
      @(negedge clk);
      chk($sformatf("bp_hold%0d", k), {29'b0, bvalid, bresp}, 32'b110);
      chk($sformatf("bp_cnt%0d", k), wr_cnt, exp_w);
    end
    release_p = 1'b0;
    bready = 1'b1; @(posedge clk); @(negedge clk); bready = 1'b0; exp_w++;
    chk("bp_after", {15'b0, bvalid, wr_cnt}, {16'b0, exp_w[15:0]});

    // Read backpressure: rdata/rresp held while rready is low.
    araddr = 20'h0C; arvalid = 1'b1;
    @(posedge clk); @(negedge clk);
    arvalid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("rbp_data%0d", k), rdata, 32'hAA22CC44);
      chk($sformatf("rbp_vld%0d", k), {29'b0, rvalid, rresp}, 32'b100);
      @(negedge clk);
    end
    rready = 1'b1; @(posedge clk); @(negedge clk); rready = 1'b0; exp_r++;
    chk("rbp_cnt", rd_cnt, exp_r);

    // Read hang for 1000 cycles, then release.
    rd_mode = 2'd3;
    araddr = 20'h04; arvalid = 1'b1;
    @(posedge clk); @(negedge clk);
    arvalid = 1'b0; rd_mode = 2'd0;
    seen = 0;
    repeat (1000) begin
      if (rvalid || arready) seen++;
      @(negedge clk);
    end
    chk("rhang_quiet", seen, 32'd0);
    release_p = 1'b1; @(posedge clk); @(negedge clk); release_p = 1'b0;
    chk("rhang_release", {30'b0, arready, rvalid}, 32'b10);
    chk("rhang_cnt", rd_cnt, exp_r);
    rd(20'h04, r, d, lat);
    chk("after_rhang_data", d, 32'hCAFEF00D);

    // Write hang drops without touching the register.
    wr_mode = 2'd3;
    awaddr = 20'h10; wdata = 32'hFFFFFFFF; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    @(posedge clk); @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0; wr_mode = 2'd0;
    seen = 0;
    repeat (20) begin
      if (bvalid || awready || wready) seen++;
      @(negedge clk);
    end
    chk("whang_quiet", seen, 32'd0);
    release_p = 1'b1; @(posedge clk); @(negedge clk); release_p = 1'b0;
    chk("whang_release", {29'b0, awready, wready, bvalid}, 32'b110);
    rd(20'h10, r, d, lat);
    chk("whang_noupd", d, 32'd0);

    // Write hang aborted by reset while rdata holds a live value.
    rd(20'h04, r, d, lat);
    wr_mode = 2'd3;
    awaddr = 20'h04; wdata = 32'h1; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    @(posedge clk); @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0; wr_mode = 2'd0;
    chk("pre_rst_rdata", rdata, 32'hCAFEF00D);
    rst = 1'b1; @(posedge clk); @(negedge clk);
    chk("abort_readys", {29'b0, awready, wready, arready}, 32'd0);
    chk("abort_valids", {30'b0, bvalid, rvalid}, 32'd0);
    chk("abort_rdata", rdata, 32'd0);
    chk("abort_cnts", {wr_cnt, rd_cnt}, 32'd0);
    rst = 1'b0; exp_w = 0; exp_r = 0;
    @(negedge clk);
    chk("abort_readys_back", {29'b0, awready, wready, arready}, 32'd7);
    rd(20'h04, r, d, lat);
    chk("abort_regs_cleared", d, 32'd0);

    // Same-register race: read captured with the write decision sees the old value.
    wr(20'h00, 32'h1, 4'hF, r, lat);
    awaddr = 20'h00; wdata = 32'h2; wstrb = 4'hF; araddr = 20'h00;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
    @(posedge clk); @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    chk("race_valids", {30'b0, bvalid, rvalid}, 32'b11);
    chk("race_old", rdata, 32'h1);
    bready = 1'b1; rready = 1'b1; @(posedge clk); @(negedge clk); bready = 1'b0; rready = 1'b0;
    exp_w++; exp_r++;
    rd(20'h00, r, d, lat);
    chk("race_new", d, 32'h2);

    // W arrives before AW.
    wdata = 32'h55; wstrb = 4'hF; wvalid = 1'b1;
    @(posedge clk); @(negedge clk);
    wvalid = 1'b0;
    chk("w_first_held", {29'b0, awready, wready, bvalid}, 32'b100);
    @(negedge clk);
    chk("w_first_wait", {31'b0, bvalid}, 32'd0);
    awaddr = 20'h14; awvalid = 1'b1;
    @(posedge clk); @(negedge clk);
    awvalid = 1'b0;
    chk("w_first_resp", {29'b0, bvalid, bresp}, 32'b100);
    bready = 1'b1; @(posedge clk); @(negedge clk); bready = 1'b0; exp_w++;
    rd(20'h14, r, d, lat);
    chk("w_first_data", d, 32'h55);

    chk("final_cnts", {wr_cnt, rd_cnt}, {exp_w[15:0], exp_r[15:0]});
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/axil_fault_slave.md
# axil_fault_slave

AXI-Lite responder with fault injection. It sits on the downstream (m_axil) side of the firewall as the slave end of that bus. It holds a small register file and answers each write or read with a programmable response code, a programmable delay, or no response at all. This gives the firewall bench a reproducible source of SLVERR, DECERR and watchdog-timeout events.

## Interface
Parameters:
- G_ADDR_W, 20: AXI-Lite address width.
- G_DATA_W, 32: data width in bits; the strobe width is G_DATA_W/8.
- G_REG_N, 8: number of registers, a power of two (2 or more). Register k sits at byte address 4·k.
- G_DLY_W, 8: width of the response-delay counter.

Ports:
- i_clk, in, 1: clock.
- i_rst, in, 1: reset, synchronous, active-high.
- i_wr_mode, in, 2: write fault mode (00 OKAY, 01 SLVERR, 10 DECERR, 11 HANG).
- i_rd_mode, in, 2: read fault mode, same encoding.
- i_delay, in, G_DLY_W: extra response delay in cycles.
- i_release, in, 1: one-cycle pulse that drops any hung transaction.
- s_axil_awready/awvalid/awaddr/awprot: write address; awaddr is G_ADDR_W, awprot is 3.
- s_axil_wready/wvalid/wdata/wstrb: write data; wdata is G_DATA_W, wstrb is G_DATA_W/8.
- s_axil_bready/bvalid/bresp: write response; bresp is 2.
- s_axil_arready/arvalid/araddr/arprot: read address.
- s_axil_rready/rvalid/rdata/rresp: read data and response.
- o_wr_cnt, out, 16: count of completed B handshakes, wraps.
- o_rd_cnt, out, 16: count of completed R handshakes, wraps.

## Operation
- The write and read paths are independent FSMs. A simultaneous write and read to the same register are both legal. The write commits at its decision cycle; a read sampled in the same cycle returns the old value.
- Write FSM states:
  - W_IDLE: awready=1 until AW is captured and wready=1 until W is captured. AW and W may arrive in either order or together. Once both are held, this is the decision cycle:
    - If the address is out of range, the response is DECERR. Out of range means awaddr ≥ 4·G_REG_N; awaddr[1:0] is ignored.
    - Otherwise the response follows i_wr_mode.
  - On an OKAY decision, the register is updated per byte lane where wstrb=1. SLVERR, DECERR and HANG never update.
  - After the decision: go to W_DLY if i_delay>0, go to W_HANG if the mode is HANG, otherwise go to W_RESP.
  - W_DLY: counts the latched delay down to 0, then goes to W_RESP.
  - W_RESP: bvalid=1 with bresp held stable until bready. On the handshake: go to W_IDLE and increment o_wr_cnt.
  - W_HANG: bvalid=0 and both readys 0. On i_release go to W_IDLE with no response.
- Read FSM states (R_IDLE, R_DLY, R_RESP, R_HANG) mirror the write FSM:
  - arready=1 in R_IDLE.
  - The decision is made in the capture cycle, using the same out-of-range check on araddr.
  - rdata is the register value for OKAY and 0 for every error.
- i_wr_mode, i_rd_mode and i_delay are sampled only at the decision cycle. Later changes do not affect a transaction already in flight.
- awprot and arprot are ignored.

## Timing
- Reset values: all registers 0, all readys 0, bvalid/rvalid 0, bresp/rresp 00, rdata 0, counters 0, FSMs in IDLE.
- The readys rise in the first cycle after i_rst deasserts.
- Latency with i_delay=D, counted from the cycle containing the final AW/W (or AR) handshake: bvalid/rvalid are asserted D+1 cycles later.
- Throughput: at most one outstanding transaction per direction. A new address is not accepted until the response handshake completes.
- A response cannot be retracted. rdata and rresp are held constant while rvalid=1 and rready=0.
- An i_release pulse outside the HANG state is ignored.
- Asserting i_rst mid-transaction takes effect the next cycle: everything returns to reset values, with no response and no register update for the aborted transaction.

## Structure
- Shared package axil_pkg holds:
  - the response constants RESP_OKAY=00, RESP_EXOKAY=01, RESP_SLVERR=10, RESP_DECERR=11;
  - the fault-mode typedef.
- The FSM state typedefs are local to the module.
- Sub-module axil_fault_dly is a loadable down-counter with a done flag. It is instantiated once for the write path and once for the read path.

## Test plan
- Normal write and read, mode 00, i_delay=0: write 0xDEADBEEF with wstrb=F to address 0x04, then read 0x04. Required: bresp=00 and rdata=0xDEADBEEF with rresp=00, each valid exactly 1 cycle after its handshake; o_wr_cnt=1, o_rd_cnt=1.
- Partial strobe: write 0x11223344 with wstrb=0101 over an existing value of 0xAABBCCDD. Required: a readback of 0xAA22CC44.
- Error codes:
  - i_wr_mode=01, write 0x5 to address 0x08: bresp=10 and a readback of 0.
  - Read from 0x40 with G_REG_N=8: rresp=11 and rdata=0.
- Delay and backpressure:
  - i_delay=5: rvalid rises exactly 6 cycles after the AR handshake.
  - bready held low for 3 cycles: bvalid and bresp stay stable; o_wr_cnt increments only on the handshake.
- Hang and reset:
  - i_rd_mode=11 with arvalid: rvalid stays 0 for 1000 cycles.
  - An i_release pulse returns arready=1 with no response.
  - Repeat with i_rst instead of i_release: all outputs at reset values on the next cycle.
- Same-register race: an AW/W/AR handshake in the same cycle to 0x00 while the register holds 0x1, writing 0x2. Required: the read returns 0x1 and a following read returns 0x2.
